packet_framer: RTL and testbench

PACKET_FRAMER -- requirements
Module: packet_framer

---
 rtl/framer_pkg.sv | 24 ++
 rtl/bit_rate_div.sv | 31 +++
 rtl/packet_framer.sv | 112 +++++++++++
 tb/tb_packet_framer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/framer_pkg.sv
// Shared encodings and constants for packet_framer.
// The CHKSUM state exists only when PACKET_FRAMER_CHKSUM_EN is defined.
package framer_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PREAMBLE = 3'd1;
  localparam logic [2:0] ST_PAYLOAD  = 3'd2;
`ifdef PACKET_FRAMER_CHKSUM_EN
  localparam logic [2:0] ST_CHKSUM   = 3'd3;
`endif
  localparam logic [2:0] ST_DONE     = 3'd4;

  localparam logic [7:0] PREAMBLE       = 8'h7E;
  localparam int         FRAME_LEN_BASE = 40;
  localparam int         FRAME_LEN_CHK  = 48;

  // Bit period is 2**mode clocks; the divider counts down from period-1.
  function automatic logic [2:0] div_reload(input logic [1:0] m);
    logic [3:0] period;
    period = 4'd1 << m;
    return 3'(period - 4'd1);
  endfunction

endpackage

// File: rtl/bit_rate_div.sv
// Bit-advance tick generator; latches the bit-rate mode when cleared at frame start.
module bit_rate_div
  import framer_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic       clear,
  input  logic       run,
  input  logic [1:0] mode,
  output logic       tick
);

  logic [1:0] mode_q;
  logic [2:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      mode_q <= 2'd0;
      cnt    <= 3'd0;
    end else if (clear) begin
      mode_q <= mode;
      cnt    <= div_reload(mode);
    end else if (run) begin
      if (cnt == 3'd0) cnt <= div_reload(mode_q);
      else             cnt <= cnt - 3'd1;
    end
  end

  assign tick = run & (cnt == 3'd0);

endmodule

// File: rtl/packet_framer.sv
// Serialises preamble 0x7E plus four payload bytes, MSB first, at a mode-selected bit rate.
// Define PACKET_FRAMER_CHKSUM_EN to append an XOR checksum byte (48-bit frame).
module packet_framer
  import framer_pkg::*;
(
  input  logic       sys_clk,
  input  logic       sys_reset,
  input  logic       start,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  input  logic [7:0] data3,
  input  logic [1:0] mode,
  input  logic       power_down,
  output logic       packet,
  output logic       busy,
  output logic       done,
  output logic [7:0] status
);

`ifdef PACKET_FRAMER_CHKSUM_EN
  localparam int FRAME_LEN = FRAME_LEN_CHK;
`else
  localparam int FRAME_LEN = FRAME_LEN_BASE;
`endif
  // bits_left value while the last preamble bit is on the line
  localparam int PREAMBLE_LAST = FRAME_LEN - 8;

  logic [2:0]           state;
  logic                 start_q;
  logic                 start_evt;
  logic                 accept;
  logic                 tick;
  logic [FRAME_LEN-1:0] shreg;
  logic [5:0]           bits_left;
  logic                 done_flag;
  logic                 abort_flag;
  logic [4:0]           frame_cnt;

  assign start_evt = start & ~start_q;
  assign accept    = start_evt & ~power_down & (state == ST_IDLE);

`ifdef PACKET_FRAMER_CHKSUM_EN
  assign busy = (state == ST_PREAMBLE) | (state == ST_PAYLOAD) | (state == ST_CHKSUM);
`else
  assign busy = (state == ST_PREAMBLE) | (state == ST_PAYLOAD);
`endif
  assign done   = (state == ST_DONE);
  assign packet = busy & shreg[FRAME_LEN-1];
  assign status = {busy, done_flag, abort_flag, frame_cnt};

  bit_rate_div u_div (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .clear     (accept),
    .run       (busy),
    .mode      (mode),
    .tick      (tick)
  );

  always_ff @(posedge sys_clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state      <= ST_IDLE;
      start_q    <= 1'b0;
      shreg      <= '0;
      bits_left  <= 6'd0;
      done_flag  <= 1'b0;
      abort_flag <= 1'b0;
      frame_cnt  <= 5'd0;
    end else begin
      start_q <= start;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state      <= ST_PREAMBLE;
`ifdef PACKET_FRAMER_CHKSUM_EN
            shreg      <= {PREAMBLE, data0, data1, data2, data3, data0 ^ data1 ^ data2 ^ data3};
`else
            shreg      <= {PREAMBLE, data0, data1, data2, data3};
`endif
            bits_left  <= 6'(FRAME_LEN - 1);
            done_flag  <= 1'b0;
            abort_flag <= 1'b0;
          end
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          done_flag <= 1'b1;
          frame_cnt <= frame_cnt + 5'd1;
        end
        default: begin
          if (power_down) begin
            state      <= ST_IDLE;
            abort_flag <= 1'b1;
          end else if (tick) begin
            shreg     <= shreg << 1;
            bits_left <= bits_left - 6'd1;
            if (bits_left == 6'd0)
              state <= ST_DONE;
            else if (state == ST_PREAMBLE && bits_left == 6'(PREAMBLE_LAST))
              state <= ST_PAYLOAD;
`ifdef PACKET_FRAMER_CHKSUM_EN
            else if (state == ST_PAYLOAD && bits_left == 6'd8)
              state <= ST_CHKSUM;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_packet_framer.sv
// Directed self-checking bench for packet_framer; follows PACKET_FRAMER_CHKSUM_EN for frame length.
module tb_packet_framer;

`ifdef PACKET_FRAMER_CHKSUM_EN
  localparam int FLEN = 48;
`else
  localparam int FLEN = 40;
`endif

  logic       sys_clk    = 1'b0;
  logic       sys_reset  = 1'b0;
  logic       start      = 1'b0;
  logic       power_down = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00, data2 = 8'h00, data3 = 8'h00;
  logic [1:0] mode  = 2'd0;
  logic       packet, busy, done;
  logic [7:0] status;

  int         n_vec   = 0;
  int         n_err   = 0;
  int         frames  = 0;
  logic [4:0] exp_cnt = 5'd0;

  packet_framer dut (
    .sys_clk    (sys_clk),
    .sys_reset  (sys_reset),
    .start      (start),
    .data0      (data0),
    .data1      (data1),
    .data2      (data2),
    .data3      (data3),
    .mode       (mode),
    .power_down (power_down),
    .packet     (packet),
    .busy       (busy),
    .done       (done),
    .status     (status)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Runs one complete frame; poke injects a dropped mid-frame start and register changes.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input logic [1:0] m, input bit poke);
    logic [47:0] fv;
    logic [7:0]  exp_st;
    int          div;
    fv  = {8'h7E, a, b, c, d, a ^ b ^ c ^ d};
    div = 1 << m;
    data0 = a; data1 = b; data2 = c; data3 = d; mode = m;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < FLEN; i++) begin
      for (int k = 0; k < div; k++) begin
        n_vec++;
        if (packet !== fv[47-i] || busy !== 1'b1 || done !== 1'b0) begin
          n_err++;
          $display("FAIL frame_bit[%0d.%0d]: packet=%b busy=%b done=%b, required packet=%b busy=1 done=0",
                   i, k, packet, busy, done, fv[47-i]);
        end
        if (poke && i == 10 && k == 0) begin
          start = 1'b1; data0 = ~a; data1 = ~b; data3 = ~d; mode = ~m;
        end
        if (poke && i == 12 && k == 0) start = 1'b0;
        step();
      end
    end
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b0 || packet !== 1'b0) begin
      n_err++;
      $display("FAIL done_pulse: done=%b busy=%b packet=%b, required 1 0 0", done, busy, packet);
    end
    exp_cnt++;
    frames++;
    step();
    exp_st = {1'b0, 1'b1, 1'b0, exp_cnt};
    n_vec++;
    if (status !== exp_st || done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL status_after_frame: status=%h done=%b busy=%b, required status=%h done=0 busy=0",
               status, done, busy, exp_st);
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    step();
    step();
    n_vec++;
    if (packet !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || status !== 8'h00) begin
      n_err++;
      $display("FAIL reset_outputs: packet=%b busy=%b done=%b status=%h, required all 0",
               packet, busy, done, status);
    end
    start = 1'b0;
    sys_reset = 1'b1;
    step();
    step();
    n_vec++;
    if (busy !== 1'b0 || status !== 8'h00) begin
      n_err++;
      $display("FAIL idle_after_reset: busy=%b status=%h, required 0 00", busy, status);
    end
  endtask

  task automatic test_basic();
    run_frame(8'hAA, 8'hAB, 8'hAC, 8'hAD, 2'd0, 1'b0);
    n_vec++;
    if (status !== 8'h41) begin
      n_err++;
      $display("FAIL basic_status: status=%h, required 41", status);
    end
  endtask

  task automatic test_mode3_latch();
    run_frame(8'h01, 8'h02, 8'h04, 8'h08, 2'd3, 1'b1);
    step();
    n_vec++;
    if (busy !== 1'b0 || status[4:0] !== exp_cnt) begin
      n_err++;
      $display("FAIL mode3_single_count: busy=%b cnt=%0d, required busy=0 cnt=%0d", busy, status[4:0], exp_cnt);
    end
  endtask

  task automatic test_modes12();
    run_frame(8'h3C, 8'hC3, 8'h5A, 8'h96, 2'd1, 1'b0);
    run_frame(8'h80, 8'h01, 8'hFE, 8'h7F, 2'd2, 1'b1);
  endtask

  task automatic test_start_held();
    int bad;
    data0 = 8'h11; data1 = 8'h22; data2 = 8'h33; data3 = 8'h44; mode = 2'd0;
    start = 1'b1;
    step();
    bad = 0;
    for (int i = 0; i < FLEN; i++) begin
      if (busy !== 1'b1) bad++;
      step();
    end
    n_vec++;
    if (bad != 0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL held_frame: non-busy cycles=%0d done=%b, required 0 and 1", bad, done);
    end
    exp_cnt++;
    frames++;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (busy !== 1'b0 || done !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL held_no_retrigger: active cycles=%0d, required 0", bad);
    end
    start = 1'b0;
    step();
    n_vec++;
    if (status !== {3'b010, exp_cnt}) begin
      n_err++;
      $display("FAIL held_status: status=%h, required %h", status, {3'b010, exp_cnt});
    end
  endtask

  task automatic test_power_down();
    int bad;
    data0 = 8'h55; data1 = 8'h0F; data2 = 8'hF0; data3 = 8'h33; mode = 2'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) step();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL pd_pre_busy: busy=%b, required 1", busy);
    end
    power_down = 1'b1;
    step();
    n_vec++;
    if (busy !== 1'b0 || packet !== 1'b0 || done !== 1'b0 || status !== {3'b001, exp_cnt}) begin
      n_err++;
      $display("FAIL pd_abort: busy=%b packet=%b done=%b status=%h, required 0 0 0 %h",
               busy, packet, done, status, {3'b001, exp_cnt});
    end
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL pd_no_done: active cycles=%0d, required 0", bad);
    end
    power_down = 1'b0;
    step();
    n_vec++;
    if (status !== {3'b001, exp_cnt}) begin
      n_err++;
      $display("FAIL pd_abort_sticky: status=%h, required %h", status, {3'b001, exp_cnt});
    end
  endtask

  task automatic test_pd_start();
    power_down = 1'b1;
    start = 1'b1;
    step();
    step();
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL pd_start_ignored: busy=%b, required 0", busy);
    end
    power_down = 1'b0;
    step();
    step();
    n_vec++;
    if (busy !== 1'b0 || status !== {3'b001, exp_cnt}) begin
      n_err++;
      $display("FAIL pd_start_not_queued: busy=%b status=%h, required 0 %h", busy, status, {3'b001, exp_cnt});
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_wrap();
    while (frames < 33)
      run_frame(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 2'd0, 1'b0);
    n_vec++;
    if (status[4:0] !== 5'd1) begin
      n_err++;
      $display("FAIL frame_cnt_wrap: cnt=%0d, required 1", status[4:0]);
    end
  endtask

  task automatic test_reset_mid();
    data0 = 8'hC0; data1 = 8'hFF; data2 = 8'hEE; data3 = 8'h0D; mode = 2'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 24; i++) step();
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_busy: busy=%b, required 1", busy);
    end
    #2 sys_reset = 1'b0;
    #1;
    n_vec++;
    if (packet !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || status !== 8'h00) begin
      n_err++;
      $display("FAIL rstmid_async: packet=%b busy=%b done=%b status=%h, required all 0",
               packet, busy, done, status);
    end
    step();
    step();
    sys_reset = 1'b1;
    step();
    exp_cnt = 5'd0;
    n_vec++;
    if (status !== 8'h00 || done !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_release: status=%h done=%b, required 00 0", status, done);
    end
    run_frame(8'hAA, 8'hAB, 8'hAC, 8'hAD, 2'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mode3_latch();
    test_modes12();
    test_start_held();
    test_power_down();
    test_pd_start();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
